prince_output_affine_serial: RTL

- Share-wise decoder for the masked PRINCE S-box datapath. It applies the inverse of the 3-share input affine layer to a full 64-bit state.
- The state is processed one nibble per clock, using three independent 64-bit share registers with a valid/ready handshake on both sides.
- It sits after the masked S-box core and undoes the input-affine encoding before the linear layer.
- Shares are never combined. Every operation is share-local, so second-order SCA properties are preserved.

---
 rtl/prince_output_affine_serial.sv | 94 +++++++++
 1 files changed

// File: rtl/prince_output_affine_serial.sv
// Serial share-wise inverse input-affine decoder for the masked PRINCE S-box path.
// Three independent share registers are rotated right one nibble per clock; each
// nibble leaving the bottom is decoded and re-enters at the top, so after NIBBLES
// steps the original nibble ordering is restored. Shares are never combined.
module prince_output_affine_serial #(
    parameter int unsigned NIBBLES = 16,
    parameter int unsigned CNT_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] in_s1,
    input  logic [4*NIBBLES-1:0] in_s2,
    input  logic [4*NIBBLES-1:0] in_s3,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] out_s1,
    output logic [4*NIBBLES-1:0] out_s2,
    output logic [4*NIBBLES-1:0] out_s3,
    output logic                 busy
);

    localparam int unsigned W = 4 * NIBBLES;
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     s1_q;
    logic [W-1:0]     s2_q;
    logic [W-1:0]     s3_q;

    // Share 1 carries the affine constant, hence the inverted top bit.
    function automatic logic [3:0] aff_const(input logic [3:0] y);
        return {~(y[3] ^ y[1]), y[2], y[0], y[1]};
    endfunction

    function automatic logic [3:0] aff_plain(input logic [3:0] y);
        return {y[3] ^ y[1], y[2], y[0], y[1]};
    endfunction

    // Control FSM, nibble counter and the three share-local rotating registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        s1_q    <= in_s1;
                        s2_q    <= in_s2;
                        s3_q    <= in_s3;
                        cnt_q   <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    s1_q <= {aff_const(s1_q[3:0]), s1_q[W-1:4]};
                    s2_q <= {aff_plain(s2_q[3:0]), s2_q[W-1:4]};
                    s3_q <= {aff_plain(s3_q[3:0]), s3_q[W-1:4]};
                    if (cnt_q == LastCnt) begin
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Handshake flags decode straight from the state register.
    always_comb begin
        in_ready  = (state_q == StIdle);
        busy      = (state_q == StRun);
        out_valid = (state_q == StDone);
    end

    assign out_s1 = s1_q;
    assign out_s2 = s2_q;
    assign out_s3 = s3_q;

endmodule
